wb_uart_bridge: RTL and testbench

//  UART-to-Wishbone debug initiator: decodes host command frames from a UART and issues single

---
 rtl/wb_uart_bridge.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_wb_uart_bridge.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_bridge.sv
// Purpose: UART (8N1) host command decoder acting as a single-cycle Wishbone initiator (peek/poke).
// Latency: wb_cyc rises on the last frame byte's stop-bit sample edge; response TX starts 1 sys_clk after ack/err.
// Backpressure: none on RX; bytes arriving during BUS/RESP are dropped. Build option: WB_UART_BRIDGE_TIMEOUT_EN.
module wb_uart_bridge #(
  parameter int CLKS_PER_BIT   = 217,
  parameter int ADDR_WIDTH     = 32,
  parameter int TAG_WIDTH      = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  uart_rx,
  output logic                  uart_tx,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_we,
  output logic [TAG_WIDTH-1:0]  wb_tag,
  output logic [3:0]            wb_sel,
  output logic [ADDR_WIDTH-1:0] wb_adr,
  output logic [31:0]           wb_mosi,
  input  logic [31:0]           wb_miso,
  input  logic                  wb_ack,
  input  logic                  wb_err,
  output logic                  busy
);

  // Bit-period counter holds 0..CLKS_PER_BIT-1
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [7:0] CMD_WR     = 8'h01;
  localparam logic [7:0] CMD_RD     = 8'h02;
  localparam logic [7:0] STS_OK     = 8'h00;
  localparam logic [7:0] STS_ERR    = 8'hEE;
  localparam logic [7:0] STS_TMO    = 8'hEF;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {C_IDLE, C_ADDR, C_WDATA, C_BUS, C_RESP} cmd_state_e;

  // ---------------- RX ----------------
  logic            rx_meta_q, rx_sync_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_byte_vld;
  logic            rx_frame_err;

  // Two-flop synchroniser; line idles high
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX deframer: mid-bit sampling, false-start rejection, stop-bit check
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_byte_vld  = 1'b0;
    rx_frame_err = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d     = '0;
          rx_state_d   = RX_IDLE;
          rx_byte_vld  = rx_sync_q;
          rx_frame_err = !rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX state registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // ---------------- TX ----------------
  // tx_shift_q[0] is the line; it holds all ones when idle
  logic [9:0]    tx_shift_q, tx_shift_d;
  logic [3:0]    tx_bits_q, tx_bits_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          tx_load;
  logic [7:0]    tx_byte;
  logic          tx_ready;

  // Ready during the final cycle of the stop bit so bytes go out back-to-back
  assign tx_ready = (tx_bits_q == 4'd0) || ((tx_bits_q == 4'd1) && (tx_cnt_q == BIT_LAST));
  assign uart_tx  = tx_shift_q[0];

  // TX serialiser: start, 8 data LSB first, stop
  always_comb begin
    tx_shift_d = tx_shift_q;
    tx_bits_d  = tx_bits_q;
    tx_cnt_d   = tx_cnt_q;
    if (tx_load) begin
      tx_shift_d = {1'b1, tx_byte, 1'b0};
      tx_bits_d  = 4'd10;
      tx_cnt_d   = '0;
    end else if (tx_bits_q != 4'd0) begin
      if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_bits_d  = tx_bits_q - 4'd1;
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
      end else begin
        tx_cnt_d = tx_cnt_q + CW'(1);
      end
    end
  end

  // TX state registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_shift_q <= '1;
      tx_bits_q  <= '0;
      tx_cnt_q   <= '0;
    end else begin
      tx_shift_q <= tx_shift_d;
      tx_bits_q  <= tx_bits_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  // ---------------- Command FSM ----------------
  cmd_state_e state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [39:0] resp_buf_q, resp_buf_d;
  logic [2:0]  resp_left_q, resp_left_d;
  logic        tmo_hit;

`ifdef WB_UART_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Bus-cycle watchdog, cleared outside BUS
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == C_BUS) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end
  end

  assign tmo_hit = (state_q == C_BUS) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Frame decode, bus cycle control and response sequencing
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    we_d        = we_q;
    cyc_d       = cyc_q;
    addr_d      = addr_q;
    wdat_d      = wdat_q;
    resp_buf_d  = resp_buf_q;
    resp_left_d = resp_left_q;
    tx_load     = 1'b0;
    tx_byte     = resp_buf_q[39:32];
    case (state_q)
      C_IDLE: begin
        if (rx_byte_vld && (rx_shift_q == CMD_WR || rx_shift_q == CMD_RD)) begin
          state_d    = C_ADDR;
          we_d       = (rx_shift_q == CMD_WR);
          byte_cnt_d = 2'd0;
        end
      end
      C_ADDR: begin
        if (rx_frame_err) begin
          state_d = C_IDLE;
        end else if (rx_byte_vld) begin
          addr_d     = {addr_q[23:0], rx_shift_q};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (we_q) begin
              state_d = C_WDATA;
            end else begin
              state_d = C_BUS;
              cyc_d   = 1'b1;
            end
          end
        end
      end
      C_WDATA: begin
        if (rx_frame_err) begin
          state_d = C_IDLE;
        end else if (rx_byte_vld) begin
          wdat_d     = {wdat_q[23:0], rx_shift_q};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = C_BUS;
            cyc_d   = 1'b1;
          end
        end
      end
      C_BUS: begin
        // err dominates a simultaneous ack; a real response beats the watchdog
        if (wb_err) begin
          cyc_d       = 1'b0;
          state_d     = C_RESP;
          resp_buf_d  = {STS_ERR, 32'h0};
          resp_left_d = 3'd1;
        end else if (wb_ack) begin
          cyc_d       = 1'b0;
          state_d     = C_RESP;
          resp_buf_d  = we_q ? {STS_OK, 32'h0} : {STS_OK, wb_miso};
          resp_left_d = we_q ? 3'd1 : 3'd5;
        end else if (tmo_hit) begin
          cyc_d       = 1'b0;
          state_d     = C_RESP;
          resp_buf_d  = {STS_TMO, 32'h0};
          resp_left_d = 3'd1;
        end
      end
      C_RESP: begin
        if (resp_left_q != 3'd0) begin
          if (tx_ready) begin
            tx_load     = 1'b1;
            resp_buf_d  = {resp_buf_q[31:0], 8'h00};
            resp_left_d = resp_left_q - 3'd1;
          end
        end else if (tx_bits_q == 4'd0) begin
          state_d = C_IDLE;
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  // Command FSM registers; reset drops the bus cycle asynchronously
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= C_IDLE;
      byte_cnt_q  <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      addr_q      <= '0;
      wdat_q      <= '0;
      resp_buf_q  <= '0;
      resp_left_q <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      addr_q      <= addr_d;
      wdat_q      <= wdat_d;
      resp_buf_q  <= resp_buf_d;
      resp_left_q <= resp_left_d;
    end
  end

  assign wb_cyc  = cyc_q;
  assign wb_stb  = cyc_q;
  assign wb_we   = we_q;
  assign wb_tag  = '0;
  assign wb_sel  = 4'hF;
  assign wb_mosi = wdat_q;
  assign busy    = (state_q != C_IDLE);

  // Four address bytes on the wire; adapt to the bus width
  generate
    if (ADDR_WIDTH > 32) begin : g_adr_ext
      assign wb_adr = {{(ADDR_WIDTH - 32){1'b0}}, addr_q};
    end else begin : g_adr_trunc
      assign wb_adr = addr_q[ADDR_WIDTH-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_wb_uart_bridge.sv
// Purpose: randomized frame bench for wb_uart_bridge with a host UART, a Wishbone responder and a frame-level model.
// Latency: responder acks a configurable number of cycles after wb_cyc; response bytes collected by a UART monitor.
// Backpressure: host waits for the full response before sending the next frame.
module tb_wb_uart_bridge;
  localparam int CPB = 4;
`ifdef WB_UART_BRIDGE_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif
  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_BOTH = 2;
  localparam int M_NONE = 3;

  logic        clk, rst_n, uart_rx, uart_tx;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err, busy;
  logic [0:0]  wb_tag;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_mosi, wb_miso;

  int n_checks = 0;
  int n_errs   = 0;

  // responder controls and transaction log
  int          resp_mode = M_ACK;
  int          resp_dly  = 2;
  logic [31:0] miso_v    = 32'h0;
  int          txn_cnt   = 0;
  logic [31:0] t_adr, t_mosi;
  logic        t_we, t_stb;
  logic [3:0]  t_sel;
  logic [0:0]  t_tag;
  logic [7:0]  rsp_q[$];

  wb_uart_bridge #(
    .CLKS_PER_BIT(CPB), .ADDR_WIDTH(32), .TAG_WIDTH(1), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_tag(wb_tag), .wb_sel(wb_sel),
    .wb_adr(wb_adr), .wb_mosi(wb_mosi), .wb_miso(wb_miso), .wb_ack(wb_ack), .wb_err(wb_err),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wishbone responder: logs each new cycle, answers after resp_dly cycles
  initial begin
    int  wcnt;
    logic cyc_prev;
    wcnt = 0; cyc_prev = 1'b0;
    wb_ack = 1'b0; wb_err = 1'b0; wb_miso = 32'h0;
    forever begin
      @(negedge clk);
      wb_ack  = 1'b0;
      wb_err  = 1'b0;
      wb_miso = miso_v;
      if (wb_cyc && !cyc_prev) begin
        txn_cnt++;
        t_adr = wb_adr; t_we = wb_we; t_sel = wb_sel; t_tag = wb_tag;
        t_mosi = wb_mosi; t_stb = wb_stb;
      end
      cyc_prev = wb_cyc;
      if (wb_cyc) begin
        wcnt++;
        if (wcnt == resp_dly) begin
          case (resp_mode)
            M_ACK:   wb_ack = 1'b1;
            M_ERR:   wb_err = 1'b1;
            M_BOTH:  begin wb_ack = 1'b1; wb_err = 1'b1; end
            default: ;
          endcase
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Host-side UART receiver for the response stream
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n && uart_tx == 1'b0) begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        chk("tx_stop_bit", uart_tx, 1'b1);
        rsp_q.push_back(b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = bad_stop ? 1'b0 : 1'b1;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    if (bad_stop) repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input bit is_wr, input logic [31:0] a, input logic [31:0] d);
    send_byte(is_wr ? 8'h01 : 8'h02, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(a[31-8*i -: 8], 1'b0);
    if (is_wr) for (int i = 0; i < 4; i++) send_byte(d[31-8*i -: 8], 1'b0);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 4000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
  endtask

  // One host transaction checked against the frame-level model
  task automatic run_frame(input bit use_pre, input bit is_wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] m, input int mode, input int dly);
    logic [7:0]  exp_q[$];
    logic [7:0]  pre;
    logic [63:0] g;
    rsp_q.delete();
    txn_cnt = 0; resp_mode = mode; resp_dly = dly; miso_v = m;
    if (use_pre) begin
      do pre = 8'($urandom_range(0, 255)); while (pre == 8'h01 || pre == 8'h02);
      send_byte(pre, 1'b0);
    end
    send_frame(is_wr, a, d);
    wait_idle();
    if (mode == M_ACK) begin
      exp_q.push_back(8'h00);
      if (!is_wr) for (int i = 0; i < 4; i++) exp_q.push_back(m[31-8*i -: 8]);
    end else begin
      exp_q.push_back(8'hEE);
    end
    chk("rsp_count", rsp_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < rsp_q.size()) ? {56'h0, rsp_q[i]} : 64'hDEAD_0000;
      chk("rsp_byte", g, exp_q[i]);
    end
    chk("txn_count", txn_cnt, 1);
    chk("txn_adr", t_adr, a);
    chk("txn_we", t_we, is_wr);
    chk("txn_stb", t_stb, 1'b1);
    chk("txn_sel", t_sel, 4'hF);
    chk("txn_tag", t_tag, 1'b0);
    if (is_wr) chk("txn_mosi", t_mosi, d);
    chk("busy_after", busy, 1'b0);
    chk("cyc_after", wb_cyc, 1'b0);
  endtask

  task automatic wait_cyc_up();
    int t;
    t = 0;
    while (!wb_cyc && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("cyc_up", wb_cyc, 1'b1);
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", uart_tx, 1'b1);
    chk("rst_cyc", wb_cyc, 1'b0);
    chk("rst_stb", wb_stb, 1'b0);
    chk("rst_we", wb_we, 1'b0);
    chk("rst_adr", wb_adr, 32'h0);
    chk("rst_mosi", wb_mosi, 32'h0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // directed: write, read, err, ack+err
    run_frame(1'b0, 1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0, M_ACK, 2);
    run_frame(1'b0, 1'b0, 32'h0000_4000, 32'h0, 32'h1234_5678, M_ACK, 2);
    run_frame(1'b0, 1'b0, 32'h0000_4000, 32'h0, 32'h1234_5678, M_ERR, 2);
    run_frame(1'b0, 1'b0, 32'h0000_4000, 32'h0, 32'h1234_5678, M_BOTH, 2);

    // ignored command byte, partial frame aborted by a framing error
    rsp_q.delete();
    txn_cnt = 0;
    send_byte(8'h7F, 1'b0);
    repeat (2) @(negedge clk);
    chk("ignore_7f_busy", busy, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("partial_busy", busy, 1'b1);
    send_byte(8'h55, 1'b1);
    chk("frame_err_busy", busy, 1'b0);
    chk("frame_err_txn", txn_cnt, 0);
    run_frame(1'b0, 1'b0, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, M_ACK, 2);

    // randomized frames
    for (int k = 0; k < 10; k++) begin
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                int'($urandom_range(0, 2)), int'($urandom_range(1, 5)));
    end

    // reset in the middle of a bus cycle
    rsp_q.delete();
    resp_mode = M_NONE;
    send_frame(1'b0, 32'h0000_0100, 32'h0);
    wait_cyc_up();
    rst_n = 1'b0;
    #1;
    chk("midrst_cyc", wb_cyc, 1'b0);
    chk("midrst_stb", wb_stb, 1'b0);
    chk("midrst_tx", uart_tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    run_frame(1'b0, 1'b1, $urandom, $urandom, 32'h0, M_ACK, 3);

    // responder that never answers
    rsp_q.delete();
    txn_cnt = 0;
    resp_mode = M_NONE;
    send_frame(1'b0, 32'h0000_0200, 32'h0);
    wait_cyc_up();
`ifdef WB_UART_BRIDGE_TIMEOUT_EN
    t = 0;
    while (wb_cyc && t < 200) begin
      t++;
      @(negedge clk);
    end
    chk("tmo_cyc_len", t, 16);
    wait_idle();
    chk("tmo_rsp_count", rsp_q.size(), 1);
    chk("tmo_rsp_byte", (rsp_q.size() > 0) ? {56'h0, rsp_q[0]} : 64'hDEAD_0000, 8'hEF);
    chk("tmo_txn_count", txn_cnt, 1);
`else
    t = 0;
    repeat (100) @(negedge clk);
    chk("hold_cyc", wb_cyc, 1'b1);
    chk("hold_busy", busy, 1'b1);
    chk("hold_rsp_count", rsp_q.size(), 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
`endif
    run_frame(1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'hA5A5_5A5A, M_ACK, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #3000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
